decode_in: RTL and testbench

Input unpacker for the LZS decompressor. It reads 64-bit words from the source FIFO interface and converts them into an MSB-first bit stream. The stream is presented to the LZS token parser as a 16-bit look-ahead window, and the parser consumes 1–16 bits per cycle. The bit and byte ordering is exactly the one the encoder output packer produces:

- Each 64-bit word carries stream bytes in order `[7:0]` first, then `[15:8]`, up to `[63:56]` last.
- Within each byte, bit 7 comes first.

---
 rtl/decode_in.sv | 156 +++++++++++++++
 tb/tb_decode_in.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_in.sv
// Input unpacker for the LZS decompressor: 64-bit source words become an
// MSB-first bit stream shown to the token parser as a 16-bit look-ahead window.
module decode_in (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic [63:0] m_src,
   input  logic        m_src_empty,
   input  logic        m_src_endn,
   output logic        m_src_getn,
   output logic [15:0] win,
   output logic [5:0]  avail,
   input  logic        take,
   input  logic [4:0]  take_len,
   output logic        err,
   output logic        in_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAP  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        getn_d;
   logic        getn_q;
   logic        capture;

   logic [63:0] wreg;
   logic        wvalid;
   logic        wvalid_nx;
   logic [1:0]  hidx;
   logic [1:0]  hidx_nx;
   logic [31:0] acc;
   logic [31:0] acc_nx;
   logic [5:0]  cnt;
   logic [5:0]  cnt_nx;
   logic        end_seen;
   logic        end_seen_nx;
   logic        err_q;
   logic        in_done_q;

   logic        take_ok;
   logic        illegal;
   logic [5:0]  k;
   logic [5:0]  c1;
   logic [5:0]  ld_sh;
   logic        load;
   logic [15:0] hw_raw;
   logic [15:0] halfword;

   // Fetch state machine: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Fetch state machine: next state; a source marked finished is never read again
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (ce && !wvalid && !m_src_empty && m_src_endn && !end_seen) begin
               state_nx = REQ;
            end
         end
         REQ:     state_nx = CAP;
         CAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Fetch state machine: outputs
   always_comb begin
      getn_d  = (state_nx != REQ);
      capture = (state == CAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         getn_q <= 1'b1;
      end else begin
         getn_q <= getn_d;
      end
   end

   // Consume first, then top up the accumulator with the next byte-swapped halfword
   always_comb begin
      take_ok  = take && (take_len != 5'd0) && (take_len <= 5'd16) &&
                 ({1'b0, take_len} <= cnt);
      illegal  = take && !take_ok;
      k        = take_ok ? {1'b0, take_len} : 6'd0;
      c1       = cnt - k;
      load     = wvalid && (c1 <= 6'd16);
      hw_raw   = wreg[{hidx, 4'b0000} +: 16];
      halfword = {hw_raw[7:0], hw_raw[15:8]};
      ld_sh    = 6'd16 - c1;

      acc_nx = acc << k;
      cnt_nx = c1;
      if (load) begin
         acc_nx = acc_nx | ({16'h0000, halfword} << ld_sh);
         cnt_nx = c1 + 6'd16;
      end

      hidx_nx   = hidx;
      wvalid_nx = wvalid;
      if (capture) begin
         wvalid_nx = 1'b1;
         hidx_nx   = 2'd0;
      end else if (load) begin
         hidx_nx = hidx + 2'd1;
         if (hidx == 2'd3) begin
            wvalid_nx = 1'b0;
         end
      end

      end_seen_nx = end_seen | ~m_src_endn;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wreg      <= 64'h0;
         wvalid    <= 1'b0;
         hidx      <= 2'd0;
         acc       <= 32'h0;
         cnt       <= 6'd0;
         end_seen  <= 1'b0;
         err_q     <= 1'b0;
         in_done_q <= 1'b0;
      end else begin
         if (capture) begin
            wreg <= m_src;
         end
         wvalid    <= wvalid_nx;
         hidx      <= hidx_nx;
         acc       <= acc_nx;
         cnt       <= cnt_nx;
         end_seen  <= end_seen_nx;
         err_q     <= err_q | illegal;
         in_done_q <= end_seen_nx && !wvalid_nx && (state_nx == IDLE);
      end
   end

   assign m_src_getn = ce ? getn_q     : 1'bz;
   assign win        = ce ? acc[31:16] : 16'hzzzz;
   assign avail      = ce ? cnt        : 6'bzzzzzz;
   assign err        = ce ? err_q      : 1'bz;
   assign in_done    = ce ? in_done_q  : 1'bz;

endmodule

// File: tb/tb_decode_in.sv
// Directed bench for decode_in: a small FIFO model feeds words, each task
// drives one scenario and checks the window, count and flags against hand values.
module tb_decode_in;

   logic        clk;
   logic        rst;
   logic        ce;
   logic [63:0] m_src = 64'h0;
   wire         m_src_empty;
   logic        m_src_endn;
   wire         m_src_getn;
   wire  [15:0] win;
   wire  [5:0]  avail;
   logic        take;
   logic [4:0]  take_len;
   wire         err;
   wire         in_done;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [63:0] W0 = 64'h0123456789ABCDEF;
   localparam logic [63:0] W1 = 64'hFEDCBA9876543210;

   logic [63:0] fifo_mem [0:15];
   int          wr_ptr   = 0;
   int          rd_ptr   = 0;
   int          getn_cnt = 0;

   decode_in dut (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .m_src       (m_src),
      .m_src_empty (m_src_empty),
      .m_src_endn  (m_src_endn),
      .m_src_getn  (m_src_getn),
      .win         (win),
      .avail       (avail),
      .take        (take),
      .take_len    (take_len),
      .err         (err),
      .in_done     (in_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign m_src_empty = (wr_ptr == rd_ptr);

   // Source FIFO model: a low strobe pops one word, valid from the following cycle
   always @(negedge clk) begin
      if (m_src_getn === 1'b0) begin
         getn_cnt = getn_cnt + 1;
         if (rd_ptr != wr_ptr) begin
            m_src  = fifo_mem[rd_ptr % 16];
            rd_ptr = rd_ptr + 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   task automatic push(input logic [63:0] w);
      fifo_mem[wr_ptr % 16] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      take       = 1'b0;
      take_len   = 5'd0;
      m_src_endn = 1'b1;
      wr_ptr     = rd_ptr;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_avail(input int level);
      for (int i = 0; i < 30 && avail < 6'(level); i++) @(negedge clk);
   endtask

   task automatic test_reset();
      int base;
      rst        = 1'b1;
      take       = 1'b0;
      take_len   = 5'd0;
      m_src_endn = 1'b1;
      @(negedge clk);
      tests_run++;
      if (m_src_getn !== 1'b1) begin tests_failed++; $display("FAIL reset_getn: got %b expected 1", m_src_getn); end
      tests_run++;
      if (win !== 16'h0000) begin tests_failed++; $display("FAIL reset_win: got %h expected 0000", win); end
      tests_run++;
      if (avail !== 6'd0) begin tests_failed++; $display("FAIL reset_avail: got %0d expected 0", avail); end
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
      tests_run++;
      if (in_done !== 1'b0) begin tests_failed++; $display("FAIL reset_in_done: got %b expected 0", in_done); end
      base = getn_cnt;
      rst  = 1'b0;
      repeat (5) @(negedge clk);
      tests_run++;
      if (getn_cnt - base != 0) begin tests_failed++; $display("FAIL empty_no_read: got %0d reads expected 0", getn_cnt - base); end
      tests_run++;
      if (avail !== 6'd0) begin tests_failed++; $display("FAIL empty_avail: got %0d expected 0", avail); end
   endtask

   task automatic test_byte_order();
      int base;
      do_reset();
      base = getn_cnt;
      push(W0);
      wait_avail(1);
      tests_run++;
      if (avail !== 6'd16) begin tests_failed++; $display("FAIL order_avail16: got %0d expected 16", avail); end
      @(negedge clk);
      tests_run++;
      if (avail !== 6'd32) begin tests_failed++; $display("FAIL order_avail32: got %0d expected 32", avail); end
      tests_run++;
      if (win !== 16'hEFCD) begin tests_failed++; $display("FAIL order_win: got %h expected efcd", win); end
      tests_run++;
      if (getn_cnt - base != 1) begin tests_failed++; $display("FAIL order_getn_cycles: got %0d expected 1", getn_cnt - base); end
   endtask

   task automatic test_partial();
      do_reset();
      push(W0);
      wait_avail(32);
      take     = 1'b1;
      take_len = 5'd4;
      @(negedge clk);
      take = 1'b0;
      tests_run++;
      if (win !== 16'hFCDA) begin tests_failed++; $display("FAIL partial_win4: got %h expected fcda", win); end
      tests_run++;
      if (avail !== 6'd28) begin tests_failed++; $display("FAIL partial_avail4: got %0d expected 28", avail); end
      take     = 1'b1;
      take_len = 5'd16;
      @(negedge clk);
      take = 1'b0;
      tests_run++;
      if (win !== 16'hB896) begin tests_failed++; $display("FAIL partial_win16: got %h expected b896", win); end
      tests_run++;
      if (avail !== 6'd28) begin tests_failed++; $display("FAIL partial_avail16: got %0d expected 28", avail); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_hw [0:7];
      logic [15:0] got_hw [0:7];
      int          got;
      int          base;
      exp_hw = '{16'hEFCD, 16'hAB89, 16'h6745, 16'h2301,
                 16'h1032, 16'h5476, 16'h98BA, 16'hDCFE};
      for (int i = 0; i < 8; i++) got_hw[i] = 16'h0000;
      do_reset();
      base = getn_cnt;
      push(W0);
      push(W1);
      got = 0;
      for (int i = 0; i < 200 && got < 8; i++) begin
         @(negedge clk);
         if (avail >= 6'd16) begin
            got_hw[got] = win;
            got         = got + 1;
            take        = 1'b1;
            take_len    = 5'd16;
         end else begin
            take = 1'b0;
         end
      end
      @(negedge clk);
      take = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (got_hw[i] !== exp_hw[i]) begin
            tests_failed++;
            $display("FAIL stream_hw%0d: got %h expected %h", i, got_hw[i], exp_hw[i]);
         end
      end
      tests_run++;
      if (getn_cnt - base != 2) begin tests_failed++; $display("FAIL stream_getn_pulses: got %0d expected 2", getn_cnt - base); end
   endtask

   task automatic test_illegal();
      do_reset();
      push(W0);
      wait_avail(32);
      take     = 1'b1;
      take_len = 5'd20;
      @(negedge clk);
      take = 1'b0;
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL illegal20_err: got %b expected 1", err); end
      tests_run++;
      if (avail !== 6'd32) begin tests_failed++; $display("FAIL illegal20_avail: got %0d expected 32", avail); end
      tests_run++;
      if (win !== 16'hEFCD) begin tests_failed++; $display("FAIL illegal20_win: got %h expected efcd", win); end
      repeat (3) @(negedge clk);
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL illegal_sticky: got %b expected 1", err); end

      do_reset();
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL illegal_cleared: got %b expected 0", err); end
      push(W0);
      wait_avail(1);
      take     = 1'b1;
      take_len = 5'd17;
      @(negedge clk);
      take = 1'b0;
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL illegal17_err: got %b expected 1", err); end
      tests_run++;
      if (avail !== 6'd32) begin tests_failed++; $display("FAIL illegal17_avail: got %0d expected 32", avail); end
      tests_run++;
      if (win !== 16'hEFCD) begin tests_failed++; $display("FAIL illegal17_win: got %h expected efcd", win); end
   endtask

   task automatic test_end();
      int base;
      int got;
      do_reset();
      base = getn_cnt;
      push(W0);
      push(W1);
      for (int i = 0; i < 30 && m_src_getn !== 1'b0; i++) @(negedge clk);
      m_src_endn = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_done !== 1'b0) begin tests_failed++; $display("FAIL end_busy: got %b expected 0", in_done); end
      got = 0;
      for (int i = 0; i < 100 && got < 4; i++) begin
         @(negedge clk);
         if (avail >= 6'd16) begin
            got      = got + 1;
            take     = 1'b1;
            take_len = 5'd16;
         end else begin
            take = 1'b0;
         end
      end
      @(negedge clk);
      take = 1'b0;
      for (int i = 0; i < 20 && in_done !== 1'b1; i++) @(negedge clk);
      tests_run++;
      if (in_done !== 1'b1) begin tests_failed++; $display("FAIL end_done: got %b expected 1", in_done); end
      tests_run++;
      if (avail !== 6'd0) begin tests_failed++; $display("FAIL end_avail: got %0d expected 0", avail); end
      repeat (10) @(negedge clk);
      tests_run++;
      if (getn_cnt - base != 1) begin tests_failed++; $display("FAIL end_no_more_reads: got %0d expected 1", getn_cnt - base); end
      tests_run++;
      if (in_done !== 1'b1) begin tests_failed++; $display("FAIL end_done_hold: got %b expected 1", in_done); end
   endtask

   task automatic test_reset_mid_read();
      int base;
      do_reset();
      take     = 1'b1;
      take_len = 5'd0;
      @(negedge clk);
      take = 1'b0;
      tests_run++;
      if (err !== 1'b1) begin tests_failed++; $display("FAIL midrst_err_set: got %b expected 1", err); end
      base = getn_cnt;
      push(W1);
      push(W0);
      for (int i = 0; i < 30 && m_src_getn !== 1'b0; i++) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (m_src_getn !== 1'b1) begin tests_failed++; $display("FAIL midrst_getn: got %b expected 1", m_src_getn); end
      tests_run++;
      if (win !== 16'h0000) begin tests_failed++; $display("FAIL midrst_win: got %h expected 0000", win); end
      tests_run++;
      if (avail !== 6'd0) begin tests_failed++; $display("FAIL midrst_avail: got %0d expected 0", avail); end
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL midrst_err: got %b expected 0", err); end
      tests_run++;
      if (in_done !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_done: got %b expected 0", in_done); end
      @(negedge clk);
      rst = 1'b0;
      wait_avail(1);
      tests_run++;
      if (win !== 16'hEFCD) begin tests_failed++; $display("FAIL midrst_next_word: got %h expected efcd", win); end
      tests_run++;
      if (getn_cnt - base != 2) begin tests_failed++; $display("FAIL midrst_reads: got %0d expected 2", getn_cnt - base); end
   endtask

   initial begin
      ce         = 1'b1;
      rst        = 1'b1;
      take       = 1'b0;
      take_len   = 5'd0;
      m_src_endn = 1'b1;
      test_reset();
      test_byte_order();
      test_partial();
      test_back_to_back();
      test_illegal();
      test_end();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
